intersection_phase_sequencer: RTL and testbench



---
 rtl/intersection_phase_sequencer_if.sv | 27 ++
 rtl/intersection_phase_sequencer.sv | 150 +++++++++++++++
 tb/tb_intersection_phase_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_phase_sequencer_if.sv
// Signal bundle between the intersection phase sequencer and its environment:
// vehicle/pedestrian demand inputs, lamp drives, walk acknowledge and debug phase.
interface intersection_phase_sequencer_if;
  logic       S;
  logic       ped_req;
  logic       ped_ack;
  logic       hw_r;
  logic       hw_y;
  logic       hw_g;
  logic       cr_r;
  logic       cr_y;
  logic       cr_g;
  logic       walk;
  logic [2:0] phase;

  // Environment side: sensors/buttons in, lamps observed.
  modport master (
    output S, ped_req,
    input  ped_ack, hw_r, hw_y, hw_g, cr_r, cr_y, cr_g, walk, phase
  );

  // Controller side.
  modport slave (
    input  S, ped_req,
    output ped_ack, hw_r, hw_y, hw_g, cr_r, cr_y, cr_g, walk, phase
  );
endinterface

// File: rtl/intersection_phase_sequencer.sv
// Moore-style timed phase sequencer for a highway / country-road intersection
// with a latched pedestrian walk phase served between the two roads.
module intersection_phase_sequencer #(
  parameter int HW_MIN = 8,
  parameter int CR_MAX = 6,
  parameter int YEL_T  = 3,
  parameter int AR_T   = 1,
  parameter int WALK_T = 4,
  parameter int CW     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  intersection_phase_sequencer_if.slave sig
);

  typedef enum logic [2:0] {
    HW_G    = 3'd0,
    HW_Y    = 3'd1,
    AR1     = 3'd2,
    CR_G    = 3'd3,
    CR_Y    = 3'd4,
    AR2     = 3'd5,
    WALK    = 3'd6,
    ILLEGAL = 3'd7
  } state_t;

  // Terminal timer values: a phase of duration N ends when timer == N-1.
  localparam logic [CW-1:0] HW_LAST   = CW'(HW_MIN - 1);
  localparam logic [CW-1:0] CR_LAST   = CW'(CR_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(YEL_T - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(AR_T - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK_T - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] timer, timer_nxt;
  logic          ped_pending, pend_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HW_G;
      timer       <= '0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      ped_pending <= pend_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HW_G: begin
        if ((timer >= HW_LAST) && (sig.S || ped_pending)) state_nxt = HW_Y;
      end
      HW_Y: begin
        if (timer == YEL_LAST) state_nxt = AR1;
      end
      AR1: begin
        if (timer == AR_LAST) begin
          if (ped_pending)     state_nxt = WALK;
          else if (sig.S)      state_nxt = CR_G;
          else                 state_nxt = HW_G;
        end
      end
      WALK: begin
        if (timer == WALK_LAST) state_nxt = sig.S ? CR_G : HW_G;
      end
      CR_G: begin
        if (!sig.S || (timer == CR_LAST)) state_nxt = CR_Y;
      end
      CR_Y: begin
        if (timer == YEL_LAST) state_nxt = AR2;
      end
      AR2: begin
        if (timer == AR_LAST) state_nxt = HW_G;
      end
      default: state_nxt = HW_G;
    endcase
  end

  // Phase timer: restarts on every phase change; highway green parks at its
  // minimum so an idle highway can hold green indefinitely without wrapping.
  always_comb begin
    timer_nxt = timer + 1'b1;
    if (state_nxt != state)
      timer_nxt = '0;
    else if ((state == HW_G) && (timer >= HW_LAST))
      timer_nxt = HW_LAST;
  end

  // Pedestrian latch: cleared when walk is granted (wins over a new press on
  // that same edge); presses during an active walk are already being served.
  always_comb begin
    pend_nxt = ped_pending;
    if ((state == AR1) && (state_nxt == WALK))
      pend_nxt = 1'b0;
    else if (sig.ped_req && (state != WALK))
      pend_nxt = 1'b1;
  end

  // Lamp decode from the state register only.
  always_comb begin
    sig.hw_r    = 1'b0;
    sig.hw_y    = 1'b0;
    sig.hw_g    = 1'b0;
    sig.cr_r    = 1'b0;
    sig.cr_y    = 1'b0;
    sig.cr_g    = 1'b0;
    sig.walk    = 1'b0;
    sig.ped_ack = 1'b0;
    sig.phase   = state;
    unique case (state)
      HW_G: begin
        sig.hw_g = 1'b1;
        sig.cr_r = 1'b1;
      end
      HW_Y: begin
        sig.hw_y = 1'b1;
        sig.cr_r = 1'b1;
      end
      CR_G: begin
        sig.hw_r = 1'b1;
        sig.cr_g = 1'b1;
      end
      CR_Y: begin
        sig.hw_r = 1'b1;
        sig.cr_y = 1'b1;
      end
      WALK: begin
        sig.hw_r    = 1'b1;
        sig.cr_r    = 1'b1;
        sig.walk    = 1'b1;
        sig.ped_ack = (timer == '0);
      end
      default: begin
        // AR1, AR2 and the illegal code all show red both ways.
        sig.hw_r = 1'b1;
        sig.cr_r = 1'b1;
      end
    endcase
  end

  // Safety invariants on the lamp drive.
  a_hw_onehot : assert property (@(posedge clk) $onehot({sig.hw_r, sig.hw_y, sig.hw_g}));
  a_cr_onehot : assert property (@(posedge clk) $onehot({sig.cr_r, sig.cr_y, sig.cr_g}));
  a_no_conflict : assert property (@(posedge clk) !(sig.walk && !(sig.hw_r && sig.cr_r)));

endmodule

// File: tb/tb_intersection_phase_sequencer.sv
// Scoreboarded bench: each scenario pushes its expected per-cycle phase/lamp
// timeline, then drives S/ped_req/reset cycle by cycle and compares at negedge.
module tb_intersection_phase_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // {phase, hw_r, hw_y, hw_g, cr_r, cr_y, cr_g, walk, ped_ack}
  logic [10:0] exp_q[$];
  logic [10:0] exp_v;
  logic [10:0] obs_v;

  intersection_phase_sequencer_if ifc ();

  intersection_phase_sequencer #(
    .HW_MIN(8), .CR_MAX(6), .YEL_T(3), .AR_T(1), .WALK_T(4), .CW(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sig  (ifc.slave)
  );

  always #5 clk = ~clk;

  assign obs_v = {ifc.phase, ifc.hw_r, ifc.hw_y, ifc.hw_g, ifc.cr_r, ifc.cr_y,
                  ifc.cr_g, ifc.walk, ifc.ped_ack};

  // Expected lamp set per phase code, straight from the lamp table.
  function automatic logic [6:0] lamps_of(input int ph);
    case (ph)
      0:       return 7'b0011000;
      1:       return 7'b0101000;
      2:       return 7'b1001000;
      3:       return 7'b1000010;
      4:       return 7'b1000100;
      5:       return 7'b1001000;
      6:       return 7'b1001001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic push_seg(input int ph, input int n);
    logic [2:0] p3;
    p3 = 3'(ph);
    for (int i = 0; i < n; i++)
      exp_q.push_back({p3, lamps_of(ph), (ph == 6 && i == 0)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.S = 1'b0;
    ifc.ped_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.S = 1'b1;
    ifc.ped_req = 1'b1;
    exp_q.delete();
    push_seg(0, 2);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset edge %0d got %b want %b", c, obs_v, exp_v);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    exp_q.delete();
    push_seg(0, 40);
    for (int c = 0; c < 40; c++) begin
      ifc.S = 1'b0;
      ifc.ped_req = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL idle cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_country_cap();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(3, 6);
    push_seg(4, 3); push_seg(5, 1); push_seg(0, 8); push_seg(1, 2);
    for (int c = 0; c < 32; c++) begin
      ifc.S = 1'b1;
      ifc.ped_req = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL country_cap cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_country_early_end();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(3, 2);
    push_seg(4, 3); push_seg(5, 1); push_seg(0, 6);
    for (int c = 0; c < 24; c++) begin
      ifc.S = (c <= 12);
      ifc.ped_req = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL country_early cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ped_walk();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(6, 4); push_seg(0, 14);
    for (int c = 0; c < 30; c++) begin
      ifc.S = 1'b0;
      ifc.ped_req = (c == 3 || c == 13);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL ped_walk cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ped_then_country();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(6, 4);
    push_seg(3, 6); push_seg(4, 3); push_seg(5, 1); push_seg(0, 4);
    for (int c = 0; c < 30; c++) begin
      ifc.S = 1'b1;
      ifc.ped_req = (c == 2);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL ped_country cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset mid country-green with a pedestrian latched: the latch must be
  // dropped, so the next AR1 goes to country green rather than walk.
  task automatic test_reset_midphase();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(3, 3);
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(3, 3);
    for (int c = 0; c < 30; c++) begin
      ifc.S = 1'b1;
      ifc.ped_req = (c == 13);
      reset = (c == 14);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_mid cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Late press after highway minimum has long elapsed (saturated timer), plus
  // a press on the AR1->WALK edge which must be swallowed by the grant.
  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    push_seg(0, 12); push_seg(1, 3); push_seg(2, 1); push_seg(6, 4); push_seg(0, 10);
    for (int c = 0; c < 30; c++) begin
      ifc.S = 1'b0;
      ifc.ped_req = (c == 10 || c == 15);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_demand_withdrawn();
    do_reset();
    exp_q.delete();
    push_seg(0, 8); push_seg(1, 3); push_seg(2, 1); push_seg(0, 14);
    for (int c = 0; c < 26; c++) begin
      ifc.S = (c <= 7);
      ifc.ped_req = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL withdrawn cycle %0d got %b want %b", c, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ifc.S = 1'b0;
    ifc.ped_req = 1'b0;
    test_reset();
    test_idle();
    test_country_cap();
    test_country_early_end();
    test_ped_walk();
    test_ped_then_country();
    test_reset_midphase();
    test_back_to_back();
    test_demand_withdrawn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
